// File: rtl/ralu_pkg.sv
// Shared RALU register-file types: register count, the hard-wired zero register and the
// address/data pair that travels toward the register-file write port.
package ralu_pkg;

    localparam int unsigned RALU_DATA_W = 16;
    localparam int unsigned RALU_ADDR_W = 4;
    localparam int unsigned NUM_REGS    = 2 ** RALU_ADDR_W;

    localparam logic [RALU_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [RALU_ADDR_W-1:0] addr;
        logic [RALU_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic is_zero_reg(input logic [RALU_ADDR_W-1:0] a);
        return a == REG_ZERO;
    endfunction

endpackage

// File: rtl/ralu_wb_fifo.sv
// Small synchronous FIFO of wb_entry_t used to buffer load results ahead of write-back.
// A push while full is dropped and a pop while empty is ignored.
module ralu_wb_fifo
    import ralu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  wb_entry_t                    i_entry,
    input  logic                         i_pop,
    output wb_entry_t                    o_head,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !o_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
    end

endmodule

// File: rtl/ralu_writeback.sv
// RALU write-back: arbitrates ALU results against buffered loads, registers the winner onto the
// register-file write port and keeps a busy scoreboard for decode. Optional: RALU_WB_BYPASS_EN.
module ralu_writeback
    import ralu_pkg::*;
#(
    parameter int unsigned DATA_W       = RALU_DATA_W,
    parameter int unsigned ADDR_W       = RALU_ADDR_W,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              sys_clock,
    input  logic              sys_reset_n,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              rf_w_en,
    output logic [ADDR_W-1:0] rf_addr_result,
    output logic [DATA_W-1:0] rf_data_write,
    input  logic [ADDR_W-1:0] chk_addr0,
    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr_dst,
    output logic              stall,
    output logic              byp_hit0,
    output logic              byp_hit1,
    output logic [DATA_W-1:0] byp_data0,
    output logic [DATA_W-1:0] byp_data1
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t          w_ld_entry;
    wb_entry_t          w_fifo_head;
    wb_entry_t          w_win;
    logic               w_fifo_empty;
    logic [CNT_W-1:0]   w_fifo_count;
    logic               w_override;
    logic               w_pop;
    logic               w_win_valid;
    logic               w_commit;
    logic [NUM_REGS-1:0] w_busy_d;
    logic               w_src0_busy;
    logic               w_src1_busy;
    logic               w_dst_busy;

    logic [STV_W-1:0]    r_starve;
    logic                r_w_en;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [NUM_REGS-1:0] r_busy;

    assign w_ld_entry = '{addr: ld_addr, data: ld_data};

    ralu_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_ld_fifo (
        .i_clk   (sys_clock),
        .i_rst_n (sys_reset_n),
        .i_push  (ld_valid && ld_ready),
        .i_entry (w_ld_entry),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // ALU normally wins; a load head that has lost STARVE_LIMIT times in a row takes the port.
    always_comb begin
        w_override  = !w_fifo_empty && (r_starve >= STV_W'(STARVE_LIMIT));
        alu_ready   = sys_reset_n && alu_valid && !w_override;
        ld_ready    = sys_reset_n && (w_fifo_count < CNT_W'(FIFO_DEPTH));
        w_pop       = !w_fifo_empty && (!alu_valid || w_override);
        w_win_valid = alu_ready || w_pop;
        w_win       = alu_ready ? '{addr: alu_addr, data: alu_data} : w_fifo_head;
        w_commit    = w_win_valid && !is_zero_reg(w_win.addr);
    end

    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_starve <= '0;
        end else if (w_pop) begin
            r_starve <= '0;
        end else if (!w_fifo_empty && alu_valid && (r_starve < STV_W'(STARVE_LIMIT))) begin
            r_starve <= r_starve + STV_W'(1);
        end
    end

    // A winner targeting R0 is consumed without a write; address/data then hold.
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_w_en <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_w_en <= w_commit;
            if (w_commit) begin
                r_addr <= w_win.addr;
                r_data <= w_win.data;
            end
        end
    end

    assign rf_w_en        = r_w_en;
    assign rf_addr_result = r_addr;
    assign rf_data_write  = r_data;

    // Issue is applied after the commit clear so a same-edge set wins.
    always_comb begin
        w_busy_d = r_busy;
        if (r_w_en) w_busy_d[r_addr] = 1'b0;
        if (iss_valid && !is_zero_reg(iss_addr)) w_busy_d[iss_addr] = 1'b1;
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    always_comb begin
        w_src0_busy = r_busy[chk_addr0] && !is_zero_reg(chk_addr0);
        w_src1_busy = r_busy[chk_addr1] && !is_zero_reg(chk_addr1);
        w_dst_busy  = r_busy[chk_addr_dst] && !is_zero_reg(chk_addr_dst);
`ifdef RALU_WB_BYPASS_EN
        byp_hit0  = r_w_en && (r_addr == chk_addr0) && !is_zero_reg(chk_addr0);
        byp_hit1  = r_w_en && (r_addr == chk_addr1) && !is_zero_reg(chk_addr1);
        byp_data0 = r_data;
        byp_data1 = r_data;
        stall     = (w_src0_busy && !byp_hit0) || (w_src1_busy && !byp_hit1) || w_dst_busy;
`else
        byp_hit0  = 1'b0;
        byp_hit1  = 1'b0;
        byp_data0 = '0;
        byp_data1 = '0;
        stall     = w_src0_busy || w_src1_busy || w_dst_busy;
`endif
    end

endmodule

// File: tb/tb_ralu_writeback.sv
// Self-checking bench for ralu_writeback: directed scenarios followed by random traffic, all
// compared against a queue-based behavioural model of the write-back port.
module tb_ralu_writeback;

    logic        sys_clock = 1'b0;
    logic        sys_reset_n = 1'b0;
    logic        iss_valid = 1'b0;
    logic [3:0]  iss_addr = '0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [3:0]  alu_addr = '0;
    logic [15:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [3:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic        rf_w_en;
    logic [3:0]  rf_addr_result;
    logic [15:0] rf_data_write;
    logic [3:0]  chk_addr0 = '0;
    logic [3:0]  chk_addr1 = '0;
    logic [3:0]  chk_addr_dst = '0;
    logic        stall;
    logic        byp_hit0;
    logic        byp_hit1;
    logic [15:0] byp_data0;
    logic [15:0] byp_data1;

    ralu_writeback dut (
        .sys_clock      (sys_clock),
        .sys_reset_n    (sys_reset_n),
        .iss_valid      (iss_valid),
        .iss_addr       (iss_addr),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_addr       (alu_addr),
        .alu_data       (alu_data),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .rf_w_en        (rf_w_en),
        .rf_addr_result (rf_addr_result),
        .rf_data_write  (rf_data_write),
        .chk_addr0      (chk_addr0),
        .chk_addr1      (chk_addr1),
        .chk_addr_dst   (chk_addr_dst),
        .stall          (stall),
        .byp_hit0       (byp_hit0),
        .byp_hit1       (byp_hit1),
        .byp_data0      (byp_data0),
        .byp_data1      (byp_data1)
    );

    always #5 sys_clock = ~sys_clock;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
    } ent_t;

    ent_t        m_q[$];
    int          m_starve;
    bit          m_busy[16];
    logic        m_wen;
    logic [3:0]  m_addr;
    logic [15:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_starve = 0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_wen  = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    // One clock cycle: check combinational outputs against the model, advance the model,
    // clock the DUT and check the registered write port.
    task automatic step();
        bit   empty, ovr, ardy, pop, lrdy, h0, h1, s0, s1, sd, stl, wv;
        ent_t win;
        #1;
        empty = (m_q.size() == 0);
        ovr   = !empty && (m_starve >= 3);
        ardy  = alu_valid && !ovr;
        pop   = !empty && (!alu_valid || ovr);
        lrdy  = (m_q.size() < 2);
        s0    = (chk_addr0 != 0) && m_busy[chk_addr0];
        s1    = (chk_addr1 != 0) && m_busy[chk_addr1];
        sd    = (chk_addr_dst != 0) && m_busy[chk_addr_dst];
`ifdef RALU_WB_BYPASS_EN
        h0 = m_wen && (m_addr == chk_addr0) && (chk_addr0 != 0);
        h1 = m_wen && (m_addr == chk_addr1) && (chk_addr1 != 0);
`else
        h0 = 1'b0;
        h1 = 1'b0;
`endif
        stl = (s0 && !h0) || (s1 && !h1) || sd;
        chk("alu_ready", alu_ready, ardy);
        chk("ld_ready", ld_ready, lrdy);
        chk("stall", stall, stl);
        chk("byp_hit0", byp_hit0, h0);
        chk("byp_hit1", byp_hit1, h1);
        chk("byp_data0", byp_data0, h0 ? m_data : 16'h0);
        chk("byp_data1", byp_data1, h1 ? m_data : 16'h0);

        wv = 1'b0;
        if (ardy) begin
            win = '{alu_addr, alu_data};
            wv  = 1'b1;
        end else if (pop) begin
            win = m_q[0];
            wv  = 1'b1;
        end
        if (pop) begin
            void'(m_q.pop_front());
            m_starve = 0;
        end else if (!empty && alu_valid) begin
            m_starve++;
        end
        if (ld_valid && lrdy) m_q.push_back('{ld_addr, ld_data});
        if (m_wen) m_busy[m_addr] = 1'b0;
        if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        if (wv && win.a != 0) begin
            m_wen  = 1'b1;
            m_addr = win.a;
            m_data = win.d;
        end else begin
            m_wen = 1'b0;
        end

        @(posedge sys_clock);
        #1;
        chk("rf_w_en", rf_w_en, m_wen);
        chk("rf_addr_result", rf_addr_result, m_addr);
        chk("rf_data_write", rf_data_write, m_data);
    endtask

    initial begin
        model_reset();
        alu_valid = 1'b1;
        alu_addr  = 4'd4;
        repeat (2) @(posedge sys_clock);
        #1;
        chk("rst_w_en", rf_w_en, 1'b0);
        chk("rst_addr", rf_addr_result, 4'd0);
        chk("rst_data", rf_data_write, 16'h0);
        chk("rst_ld_ready", ld_ready, 1'b0);
        chk("rst_alu_ready", alu_ready, 1'b0);
        alu_valid = 1'b0;
        @(negedge sys_clock);
        sys_reset_n = 1'b1;
        @(posedge sys_clock);
        #1;

        // ALU write to R3
        alu_valid = 1'b1;
        alu_addr  = 4'd3;
        alu_data  = 16'h1234;
        #1;
        chk("t1_alu_ready", alu_ready, 1'b1);
        step();
        chk("t1_w_en", rf_w_en, 1'b1);
        chk("t1_addr", rf_addr_result, 4'd3);
        chk("t1_data", rf_data_write, 16'h1234);
        alu_valid = 1'b0;

        // Scoreboard hazard on R5 until the commit edge
        iss_valid = 1'b1;
        iss_addr  = 4'd5;
        step();
        iss_valid = 1'b0;
        chk_addr0 = 4'd5;
        #1;
        chk("t2_stall_busy", stall, 1'b1);
        step();
        alu_valid = 1'b1;
        alu_addr  = 4'd5;
        alu_data  = 16'h55AA;
        step();
        alu_valid = 1'b0;
        #1;
`ifdef RALU_WB_BYPASS_EN
        chk("t2_stall_bypassed", stall, 1'b0);
        chk("t2_byp_hit0", byp_hit0, 1'b1);
        chk("t2_byp_data0", byp_data0, 16'h55AA);
`else
        chk("t2_stall_commit_cycle", stall, 1'b1);
`endif
        step();
        #1;
        chk("t2_stall_cleared", stall, 1'b0);
        chk_addr0 = 4'd0;

        // Two back-to-back loads with the ALU idle, written in order
        ld_valid = 1'b1;
        ld_addr  = 4'd6;
        ld_data  = 16'h0606;
        step();
        ld_addr = 4'd7;
        ld_data = 16'h0707;
        step();
        ld_valid = 1'b0;
        chk("t3_first_addr", rf_addr_result, 4'd6);
        chk("t3_first_data", rf_data_write, 16'h0606);
        step();
        chk("t3_second_addr", rf_addr_result, 4'd7);
        chk("t3_second_data", rf_data_write, 16'h0707);

        // Starvation override after three lost arbitrations
        alu_valid = 1'b1;
        alu_addr  = 4'd1;
        alu_data  = 16'h1000;
        ld_valid  = 1'b1;
        ld_addr   = 4'd9;
        ld_data   = 16'h0909;
        step();
        ld_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alu_data = 16'h1001 + 16'(i);
            #1;
            chk("t4_alu_wins", alu_ready, 1'b1);
            step();
        end
        #1;
        chk("t4_alu_held", alu_ready, 1'b0);
        step();
        chk("t4_load_addr", rf_addr_result, 4'd9);
        chk("t4_load_data", rf_data_write, 16'h0909);
        alu_valid = 1'b0;
        step();

        // Write to R0 is consumed without a register-file write
        alu_valid = 1'b1;
        alu_addr  = 4'd0;
        alu_data  = 16'hFFFF;
        #1;
        chk("t5_alu_ready", alu_ready, 1'b1);
        step();
        chk("t5_w_en", rf_w_en, 1'b0);
        alu_valid = 1'b0;
        step();

        // Reset with a full load FIFO and a live write
        alu_valid = 1'b1;
        alu_addr  = 4'd2;
        alu_data  = 16'h2222;
        ld_valid  = 1'b1;
        ld_addr   = 4'd10;
        ld_data   = 16'h0A0A;
        step();
        ld_addr = 4'd11;
        ld_data = 16'h0B0B;
        step();
        ld_valid = 1'b0;
        #1;
        chk("t6_full", ld_ready, 1'b0);
        chk("t6_w_en_live", rf_w_en, 1'b1);
        sys_reset_n = 1'b0;
        #1;
        chk("t6_rst_w_en", rf_w_en, 1'b0);
        chk("t6_rst_addr", rf_addr_result, 4'd0);
        chk("t6_rst_data", rf_data_write, 16'h0);
        chk("t6_rst_ld_ready", ld_ready, 1'b0);
        chk("t6_rst_alu_ready", alu_ready, 1'b0);
        model_reset();
        idle_inputs();
        @(negedge sys_clock);
        sys_reset_n = 1'b1;
        @(posedge sys_clock);
        #1;
        step();
        step();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            alu_valid    = 1'($urandom_range(0, 1));
            alu_addr     = 4'($urandom_range(0, 15));
            alu_data     = 16'($urandom);
            ld_valid     = 1'($urandom_range(0, 1));
            ld_addr      = 4'($urandom_range(0, 15));
            ld_data      = 16'($urandom);
            iss_valid    = ($urandom_range(0, 2) == 0);
            iss_addr     = 4'($urandom_range(0, 15));
            chk_addr0    = 4'($urandom_range(0, 15));
            chk_addr1    = 4'($urandom_range(0, 15));
            chk_addr_dst = 4'($urandom_range(0, 15));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
